// File: rtl/mini_rv_pkg.sv
// Shared types and constants for the mini RV fetch path.
package mini_rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } fetch_word_t;

  // Instruction fetch is word-granular; low address bits are simply dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry buffer that keeps the imem word dropped during a stall until the stall releases.
module fetch_hold_buffer
  import mini_rv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        drain,
  input  logic        flush,
  input  fetch_word_t word,
  output fetch_word_t held
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      held <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else if (capture && word.valid && !held.valid) begin
      // First stalled cycle only; later stall cycles see a NOP from imem.
      held <= '{instr: word.instr, pc: word.pc, valid: 1'b1};
    end else if (drain) begin
      held.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// PC generator and IF/ID register in front of a 1-cycle registered instruction memory.
// Optional: define FETCH_MISALIGN_CHECK_EN to flag misaligned redirect targets.
module fetch_stage
  import mini_rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_stall_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o,
  output logic        fetch_misaligned_o
);

  logic [31:0] pc_q;
  logic [31:0] rsp_pc_q;
  logic        rsp_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        id_valid_q;
  logic        stall_only;
  logic        advance;
  fetch_word_t rsp_word;
  fetch_word_t held;

  assign stall_only   = stall_i & ~redirect_i;
  assign advance      = ~stall_i & ~redirect_i;
  assign imem_addr_o  = pc_q;
  assign imem_stall_o = stall_only;
  assign rsp_word     = '{instr: imem_data_i, pc: rsp_pc_q, valid: rsp_valid_q};

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .reset   (reset),
    .capture (stall_only),
    .drain   (advance),
    .flush   (redirect_i),
    .word    (rsp_word),
    .held    (held)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
    end else if (redirect_i) begin
      // The word in flight and the word in ID are both wrong-path.
      pc_q        <= align_pc(redirect_pc_i);
      rsp_valid_q <= 1'b0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
    end else if (stall_i) begin
      rsp_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_q + 32'd4;
      rsp_pc_q    <= pc_q;
      rsp_valid_q <= 1'b1;
      if (held.valid) begin
        id_instr_q <= held.instr;
        id_pc_q    <= held.pc;
        id_valid_q <= 1'b1;
      end else begin
        id_instr_q <= rsp_valid_q ? imem_data_i : NOP_INSTR;
        id_pc_q    <= rsp_pc_q;
        id_valid_q <= rsp_valid_q;
      end
    end
  end

  assign id_instr_o = id_instr_q;
  assign id_pc_o    = id_pc_q;
  assign id_valid_o = id_valid_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= redirect_i & (redirect_pc_i[1:0] != 2'b00);
    end
  end

  assign fetch_misaligned_o = misaligned_q;
`else
  assign fetch_misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: models imem and checks ID against program-order PCs.
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_addr_o;
  logic        imem_stall_o;
  logic [31:0] imem_data_i = NOP;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_valid_o;
  logic        fetch_misaligned_o;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall_i            (stall_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .imem_addr_o        (imem_addr_o),
    .imem_stall_o       (imem_stall_o),
    .imem_data_i        (imem_data_i),
    .id_instr_o         (id_instr_o),
    .id_pc_o            (id_pc_o),
    .id_valid_o         (id_valid_o),
    .fetch_misaligned_o (fetch_misaligned_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // Instruction memory: registered read, NOP while stalled or in reset.
  always @(posedge clk) begin
    if (reset || imem_stall_o) imem_data_i <= NOP;
    else imem_data_i <= word_at(imem_addr_o);
  end

  // Scoreboard: architectural program-order PCs still expected to reach decode.
  logic [31:0] exp_q[$];
  logic [31:0] sb_next = RESET_PC;
  int          checks = 0;
  int          errors = 0;
  int          cycle_no = 0;

  // Directed expectation for the state visible in the current cycle.
  logic        dir_chk = 1'b0;
  logic        dir_valid = 1'b0;
  logic [31:0] dir_pc = '0;
  string       dir_name = "";

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%08h required=%08h", nm, cycle_no, act, req);
    end
  endtask

  // Monitor state from the previous cycle.
  logic        prev_reset = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_mis = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [31:0] prev_pc = '0;
  logic        prev_valid = 1'b0;
  logic [31:0] epc;
  logic        exp_mis;

  always @(negedge clk) begin
    cycle_no++;
    check("imem_stall", {31'b0, imem_stall_o}, {31'b0, stall_i & ~redirect_i});
    if (!id_valid_o) check("nop_when_invalid", id_instr_o, NOP);
    if (prev_reset) begin
      check("reset_valid", {31'b0, id_valid_o}, 32'd0);
      check("reset_pc", id_pc_o, 32'd0);
      check("reset_addr", imem_addr_o, RESET_PC);
    end
    if (prev_stall) begin
      check("stall_hold_valid", {31'b0, id_valid_o}, {31'b0, prev_valid});
      check("stall_hold_pc", id_pc_o, prev_pc);
      check("stall_hold_instr", id_instr_o, prev_instr);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_mis = prev_mis;
`else
    exp_mis = 1'b0;
`endif
    check("misaligned", {31'b0, fetch_misaligned_o}, {31'b0, exp_mis});
    if (dir_chk) begin
      check({dir_name, "_valid"}, {31'b0, id_valid_o}, {31'b0, dir_valid});
      if (dir_valid) begin
        check({dir_name, "_pc"}, id_pc_o, dir_pc);
        check({dir_name, "_instr"}, id_instr_o, word_at(dir_pc));
      end
    end
    // Decode takes the ID word when it is valid, not stalled and not squashed.
    if (!reset && id_valid_o && !stall_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", id_pc_o, 32'hDEAD_BEEF);
      end else begin
        epc = exp_q.pop_front();
        check("sb_pc", id_pc_o, epc);
        check("sb_instr", id_instr_o, word_at(epc));
        if (cycle_no < 60) $display("id word cycle=%0d pc=%08h instr=%08h", cycle_no, id_pc_o, id_instr_o);
      end
    end
    prev_reset = reset;
    prev_stall = !reset && stall_i && !redirect_i;
    prev_mis   = !reset && redirect_i && (redirect_pc_i[1:0] != 2'b00);
    prev_instr = id_instr_o;
    prev_pc    = id_pc_o;
    prev_valid = id_valid_o;
  end

  // One cycle of stimulus; chk/ev/epc describe the ID state expected in that cycle.
  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tgt,
                      input logic chk, input logic ev, input logic [31:0] xpc, input string nm);
    @(posedge clk);
    #1;
    reset         = rst;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    dir_chk       = chk;
    dir_valid     = ev;
    dir_pc        = xpc;
    dir_name      = nm;
    if (rst) begin
      exp_q.delete();
      sb_next = RESET_PC;
    end else if (rd) begin
      exp_q.delete();
      sb_next = tgt & ~32'h3;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(sb_next);
      sb_next += 32'd4;
    end
  endtask

  logic        r_rst, r_st, r_rd;
  logic [31:0] r_tgt;

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, "");
    step(1, 0, 0, 0, 0, 0, 0, "");
    // Reset release: two empty cycles, then sequential fetch from RESET_PC.
    step(0, 0, 0, 0, 1, 0, 0, "t1_empty0");
    step(0, 0, 0, 0, 1, 0, 0, "t1_empty1");
    step(0, 0, 0, 0, 1, 1, 32'h0, "t1_pc0");
    step(0, 0, 0, 0, 1, 1, 32'h4, "t1_pc4");
    // Three-cycle stall while ID holds 0x8.
    step(0, 1, 0, 0, 1, 1, 32'h8, "t2_stall0");
    step(0, 1, 0, 0, 1, 1, 32'h8, "t2_stall1");
    step(0, 1, 0, 0, 1, 1, 32'h8, "t2_stall2");
    step(0, 0, 0, 0, 1, 1, 32'h8, "t2_release");
    step(0, 0, 0, 0, 1, 1, 32'hC, "t2_heldword");
    // Redirect to 0x40 while ID holds 0x10.
    step(0, 0, 1, 32'h40, 1, 1, 32'h10, "t3_pre");
    step(0, 0, 0, 0, 1, 0, 0, "t3_gap0");
    step(0, 0, 0, 0, 1, 0, 0, "t3_gap1");
    // Redirect and stall together: redirect wins.
    step(0, 1, 1, 32'h80, 1, 1, 32'h40, "t3_target");
    step(0, 0, 0, 0, 1, 0, 0, "t4_gap0");
    step(0, 0, 0, 0, 1, 0, 0, "t4_gap1");
    // Stall captures a word, then a redirect discards it.
    step(0, 1, 0, 0, 1, 1, 32'h80, "t4_target");
    step(0, 1, 0, 0, 1, 1, 32'h80, "t5_stall");
    step(0, 0, 1, 32'h20, 1, 1, 32'h80, "t5_redir");
    step(0, 0, 0, 0, 1, 0, 0, "t5_gap0");
    step(0, 0, 0, 0, 1, 0, 0, "t5_gap1");
    // Misaligned redirect target 0x42.
    step(0, 0, 1, 32'h42, 1, 1, 32'h20, "t5_target");
    step(0, 0, 0, 0, 1, 0, 0, "t6_gap0");
    step(0, 0, 0, 0, 1, 0, 0, "t6_gap1");
    step(0, 0, 0, 0, 1, 1, 32'h40, "t6_aligned");
    // PC wrap from 0xFFFF_FFFC to 0.
    step(0, 0, 1, 32'hFFFF_FFF8, 1, 1, 32'h44, "t6_next");
    step(0, 0, 0, 0, 1, 0, 0, "wrap_gap0");
    step(0, 0, 0, 0, 1, 0, 0, "wrap_gap1");
    step(0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, "wrap_a");
    step(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, "wrap_b");
    // Reset in the middle of a stall discards the held word.
    step(1, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, "rst_stall");
    step(0, 0, 0, 0, 1, 0, 0, "rst_gap0");
    step(0, 0, 0, 0, 1, 0, 0, "rst_gap1");
    step(0, 0, 0, 0, 1, 1, RESET_PC, "rst_restart");

    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 99) < 25);
      r_rd  = ($urandom_range(0, 99) < 6);
      r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h3FF);
      step(r_rst, r_st, r_rd, r_tgt, 0, 0, 0, "");
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, "");

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
